// File: rtl/bnn_seq_ctrl_if.sv
// Feature-in / class-out handshake bundle for the sequential BNN classifier.
// The slave side belongs to the classifier; the master side to its environment.
interface bnn_seq_ctrl_if #(
  parameter int N = 11,
  parameter int B = 4,
  parameter int M = 40,
  parameter int C = 7
);
  logic [N*B-1:0]         inp;
  logic                   in_valid;
  logic                   in_ready;
  logic [$clog2(C)-1:0]   klass;
  logic [$clog2(M+1)-1:0] max_score;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output inp,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  klass,
    input  max_score,
    input  out_valid,
    input  busy
  );

  modport slave (
    input  inp,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output klass,
    output max_score,
    output out_valid,
    output busy
  );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// Time-multiplexed binarized two-layer classifier: one hidden neuron
// per clock, all class scores in parallel, then a serial argmax.
module bnn_seq_ctrl #(
  parameter int N = 11,
  parameter int M = 40,
  parameter int B = 4,
  parameter int C = 7,
  parameter logic [M*N-1:0] W1 = '0,
  parameter logic [C*M-1:0] W2 = '0
) (
  input logic           clk,
  input logic           rst_n,
  bnn_seq_ctrl_if.slave bus
);
  localparam int JW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = $clog2(C);
  localparam int SW = $clog2(M + 1);
  localparam int PW = $clog2(N + 1) + B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIDDEN,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N*B-1:0] r_feat;
  logic [JW-1:0]  r_j;
  logic [KW-1:0]  r_k;
  logic [SW-1:0]  r_score [C];
  logic [KW-1:0]  r_best_k;
  logic [SW-1:0]  r_best_s;

  logic [N-1:0]   w_w1row [M];
  logic [M-1:0]   w_w2row [C];
  logic [B-1:0]   w_inm [N];
  logic [PW-1:0]  w_pos;
  logic [PW-1:0]  w_neg;
  logic           w_mid;
  logic [C-1:0]   w_inc;
  logic           w_j_last;
  logic           w_k_last;

  // Weight rows sliced once so the datapath only needs small indices
  for (genvar gj = 0; gj < M; gj++) begin : g_w1
    assign w_w1row[gj] = W1[gj*N +: N];
  end

  for (genvar gk = 0; gk < C; gk++) begin : g_w2
    assign w_w2row[gk] = W2[gk*M +: M];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_inm
    assign w_inm[N-1-gi] = r_feat[gi*B +: B];
  end

  always_comb begin
    w_pos = '0;
    w_neg = '0;
    for (int i = 0; i < N; i++) begin
      if (w_w1row[r_j][i]) begin
        w_pos = w_pos + PW'(w_inm[i]);
      end else begin
        w_neg = w_neg + PW'(w_inm[i]);
      end
    end
  end

  assign w_mid = (w_pos >= w_neg);

  always_comb begin
    w_inc = '0;
    for (int k = 0; k < C; k++) begin
      w_inc[k] = w_w2row[k][r_j] ? w_mid : ~w_mid;
    end
  end

  assign w_j_last = (r_j == JW'(M - 1));
  assign w_k_last = (r_k == KW'(C - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.in_valid) w_next = S_HIDDEN;
      S_HIDDEN: if (w_j_last) w_next = S_ARGMAX;
      S_ARGMAX: if (w_k_last) w_next = S_DONE;
      S_DONE:   if (bus.out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_feat   <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_best_k <= '0;
      r_best_s <= '0;
      for (int k = 0; k < C; k++) begin
        r_score[k] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_feat <= bus.inp;
            r_j    <= '0;
            for (int k = 0; k < C; k++) begin
              r_score[k] <= '0;
            end
          end
        end
        S_HIDDEN: begin
          for (int k = 0; k < C; k++) begin
            r_score[k] <= r_score[k] + SW'(w_inc[k]);
          end
          if (w_j_last) begin
            r_j <= '0;
            r_k <= '0;
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        S_ARGMAX: begin
          // Strict compare keeps the lowest index on ties
          if (r_k == '0 || r_score[r_k] > r_best_s) begin
            r_best_k <= r_k;
            r_best_s <= r_score[r_k];
          end
          r_k <= r_k + KW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_HIDDEN) || (r_state == S_ARGMAX);
  assign bus.klass     = r_best_k;
  assign bus.max_score = r_best_s;
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Bench for bnn_seq_ctrl: directed small-config vectors plus
// default-size instances checked against a behavioural model.
module tb_bnn_seq_ctrl;
  localparam int DN = 11;
  localparam int DM = 40;
  localparam int DB = 4;
  localparam int DC = 7;
  localparam logic [DM*DN-1:0] W1P = {11{40'hA5C396E17B}};
  localparam logic [DC*DM-1:0] W2P = {10{28'hB4E1D27}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc = 0;
  logic act = 1'b0;
  int ek_d, es_d, ek_w, es_w;

  always @(posedge clk) cyc <= cyc + 1;

  bnn_seq_ctrl_if #(.N(2), .B(4), .M(2), .C(2)) bs ();
  bnn_seq_ctrl_if #(.N(DN), .B(DB), .M(DM), .C(DC)) bd ();
  bnn_seq_ctrl_if #(.N(DN), .B(DB), .M(DM), .C(DC)) bw ();

  bnn_seq_ctrl #(
    .N(2), .M(2), .B(4), .C(2),
    .W1(4'b0110), .W2(4'b1001)
  ) u_s (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave)
  );

  bnn_seq_ctrl #(
    .N(DN), .M(DM), .B(DB), .C(DC)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .bus(bd.slave)
  );

  bnn_seq_ctrl #(
    .N(DN), .M(DM), .B(DB), .C(DC),
    .W1(W1P), .W2(W2P)
  ) u_w (
    .clk(clk), .rst_n(rst_n), .bus(bw.slave)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Classifier evaluated straight from its definition
  function automatic void model(input logic [DN*DB-1:0] x,
                                input logic [DM*DN-1:0] w1,
                                input logic [DC*DM-1:0] w2,
                                output int k, output int s);
    int inm [DN];
    int mid [DM];
    int sc [DC];
    int pos, neg;
    for (int i = 0; i < DN; i++) inm[DN-1-i] = int'(x[i*DB +: DB]);
    for (int j = 0; j < DM; j++) begin
      pos = 0;
      neg = 0;
      for (int i = 0; i < DN; i++) begin
        if (w1[j*DN+i]) pos += inm[i];
        else neg += inm[i];
      end
      mid[j] = (pos >= neg) ? 1 : 0;
    end
    for (int c = 0; c < DC; c++) begin
      sc[c] = 0;
      for (int j = 0; j < DM; j++) sc[c] += w2[c*DM+j] ? mid[j] : 1 - mid[j];
    end
    k = 0;
    s = sc[0];
    for (int c = 1; c < DC; c++) begin
      if (sc[c] > s) begin
        k = c;
        s = sc[c];
      end
    end
  endfunction

  always @(negedge clk) begin : cmp
    int t;
    if (act) begin
      t = cyc - acc;
      chk("busy_d", bd.busy, t < DM + DC);
      chk("ovalid_d", bd.out_valid, t >= DM + DC);
      chk("iready_d", bd.in_ready, 0);
      chk("busy_w", bw.busy, t < DM + DC);
      chk("ovalid_w", bw.out_valid, t >= DM + DC);
      chk("iready_w", bw.in_ready, 0);
      if (bd.out_valid) begin
        chk("klass_d", bd.klass, ek_d);
        chk("score_d", bd.max_score, es_d);
      end
      if (bw.out_valid) begin
        chk("klass_w", bw.klass, ek_w);
        chk("score_w", bw.max_score, es_w);
      end
    end
  end

  task automatic run_big(input logic [DN*DB-1:0] v);
    int edges;
    int bsy;
    model(v, '0, '0, ek_d, es_d);
    model(v, W1P, W2P, ek_w, es_w);
    @(negedge clk);
    chk("big_iready_pre", bd.in_ready & bw.in_ready, 1);
    bd.inp = v;
    bw.inp = v;
    bd.in_valid = 1'b1;
    bw.in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    act = 1'b1;
    bd.in_valid = 1'b0;
    bw.in_valid = 1'b0;
    bd.inp = ~v;
    bw.inp = ~v;
    edges = 0;
    bsy = int'(bd.busy);
    while (!bd.out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bsy += int'(bd.busy);
    end
    chk("big_latency", edges, 47);
    chk("big_busy_cycles", bsy, 47);
    bd.out_ready = 1'b1;
    bw.out_ready = 1'b1;
    @(posedge clk);
    #1;
    act = 1'b0;
    bd.out_ready = 1'b0;
    bw.out_ready = 1'b0;
    @(negedge clk);
    chk("big_iready_post_d", bd.in_ready, 1);
    chk("big_iready_post_w", bw.in_ready, 1);
    chk("big_ovalid_post", bd.out_valid | bw.out_valid, 0);
  endtask

  task automatic run_small(input logic [7:0] v, input logic early,
                           input int ek, input int es,
                           input string nm, input int hold);
    int edges;
    @(negedge clk);
    chk({nm, "_iready_pre"}, bs.in_ready, 1);
    bs.inp = v;
    bs.in_valid = 1'b1;
    bs.out_ready = early;
    @(posedge clk);
    #1;
    bs.in_valid = 1'b0;
    bs.inp = 8'hFF;
    edges = 0;
    while (!bs.out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, edges, 4);
    chk({nm, "_klass"}, bs.klass, ek);
    chk({nm, "_score"}, bs.max_score, es);
    for (int h = 0; h < hold; h++) begin
      bs.in_valid = h[0];
      bs.inp = 8'h13;
      @(negedge clk);
      chk({nm, "_hold_ovalid"}, bs.out_valid, 1);
      chk({nm, "_hold_iready"}, bs.in_ready, 0);
      chk({nm, "_hold_klass"}, bs.klass, ek);
      chk({nm, "_hold_score"}, bs.max_score, es);
    end
    bs.in_valid = 1'b0;
    bs.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bs.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_iready_post"}, bs.in_ready, 1);
    chk({nm, "_ovalid_post"}, bs.out_valid, 0);
    chk({nm, "_busy_post"}, bs.busy, 0);
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k, s;
    logic [DN*DB-1:0] v;
    bs.inp = '0; bs.in_valid = 1'b0; bs.out_ready = 1'b0;
    bd.inp = '0; bd.in_valid = 1'b0; bd.out_ready = 1'b0;
    bw.inp = '0; bw.in_valid = 1'b0; bw.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_iready", {bs.in_ready, bd.in_ready, bw.in_ready}, 3'b111);
    chk("rst_busy", {bs.busy, bd.busy, bw.busy}, 0);
    chk("rst_ovalid", {bs.out_valid, bd.out_valid, bw.out_valid}, 0);
    chk("rst_klass", {bs.klass, bd.klass, bw.klass}, 0);
    chk("rst_score", {bs.max_score, bd.max_score, bw.max_score}, 0);
    rst_n = 1'b1;

    model('0, '0, '0, k, s);
    chk("pin_zero_k", k, 0);
    chk("pin_zero_s", s, 0);
    model(44'h1, '0, '0, k, s);
    chk("pin_one_k", k, 0);
    chk("pin_one_s", s, 40);

    run_small(8'h31, 1'b0, 1, 2, "class1", 0);
    run_small(8'h13, 1'b1, 0, 2, "class0", 0);
    run_small(8'h22, 1'b0, 0, 1, "tie", 0);
    run_small(8'h31, 1'b0, 1, 2, "bp", 10);
    @(negedge clk);
    chk("bp_idle_iready", bs.in_ready, 1);
    chk("bp_idle_busy", bs.busy, 0);

    bs.inp = 8'h31;
    bs.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bs.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", bs.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", bs.busy, 0);
    chk("mrst_ovalid", bs.out_valid, 0);
    chk("mrst_klass", bs.klass, 0);
    chk("mrst_score", bs.max_score, 0);
    chk("mrst_iready", bs.in_ready, 1);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mrst_no_result", bs.out_valid, 0);
    end
    run_small(8'h31, 1'b0, 1, 2, "post_rst", 0);

    run_big('0);
    run_big(44'h1);
    for (int n = 0; n < 198; n++) begin
      v = 44'({$urandom(), $urandom()});
      run_big(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
